// File: rtl/l1_miss_handler.sv
// Read-miss controller for a 4-way L1: looks up the L1, refills from L2 on a miss
// with a bounded wait, and answers the CPU. Optional counters: L1_MISS_HANDLER_STATS_EN.
module l1_miss_handler #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int L2_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  output logic                  cpu_resp_hit,
  output logic                  cpu_resp_err,
  output logic                  l1_read,
  output logic                  l1_write_enable,
  output logic [ADDR_WIDTH-1:0] l1_addr,
  output logic [DATA_WIDTH-1:0] l1_write_data,
  input  logic                  l1_hit,
  input  logic [DATA_WIDTH-1:0] l1_read_data,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic [ADDR_WIDTH-1:0] l2_req_addr,
  input  logic                  l2_resp_valid,
  input  logic [DATA_WIDTH-1:0] l2_resp_data
`ifdef L1_MISS_HANDLER_STATS_EN
  ,
  output logic [15:0]           stat_hits,
  output logic [15:0]           stat_misses
`endif
);

  localparam int CNT_WIDTH = (L2_TIMEOUT > 2) ? $clog2(L2_TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(L2_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    CHECK   = 3'd2,
    L2_REQ  = 3'd3,
    L2_WAIT = 3'd4,
    FILL    = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]  data_reg, data_next;
  logic                   hit_reg, hit_next;
  logic                   err_reg, err_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      hit_reg   <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      hit_reg   <= hit_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    hit_next   = hit_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_req_valid) begin
          addr_next  = cpu_req_addr;
          hit_next   = 1'b0;
          err_next   = 1'b0;
          state_next = LOOKUP;
        end
      end
      LOOKUP: state_next = CHECK;
      CHECK: begin
        if (l1_hit) begin
          data_next  = l1_read_data;
          hit_next   = 1'b1;
          state_next = RESP;
        end else begin
          state_next = L2_REQ;
        end
      end
      L2_REQ: begin
        if (l2_req_ready) begin
          cnt_next   = '0;
          state_next = L2_WAIT;
        end
      end
      L2_WAIT: begin
        // A response on the final wait cycle still wins over the timeout.
        if (l2_resp_valid) begin
          data_next  = l2_resp_data;
          state_next = FILL;
        end else if (cnt_reg == CNT_LAST) begin
          data_next  = '1;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FILL:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode state and registers only; data buses read zero when not in use.
  always_comb begin
    cpu_req_ready   = (state_reg == IDLE);
    cpu_resp_valid  = (state_reg == RESP);
    cpu_resp_data   = (state_reg == RESP) ? data_reg : '0;
    cpu_resp_hit    = (state_reg == RESP) & hit_reg;
    cpu_resp_err    = (state_reg == RESP) & err_reg;
    l1_read         = (state_reg == LOOKUP);
    l1_write_enable = (state_reg == FILL);
    l1_addr         = (state_reg == LOOKUP || state_reg == FILL) ? addr_reg : '0;
    l1_write_data   = (state_reg == FILL) ? data_reg : '0;
    l2_req_valid    = (state_reg == L2_REQ);
    l2_req_addr     = (state_reg == L2_REQ) ? addr_reg : '0;
  end

`ifdef L1_MISS_HANDLER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_reg == CHECK) begin
      if (l1_hit) begin
        if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      end else begin
        if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
      end
    end
  end
`else
  // Counters absent; the state machine above is identical in both builds.
`endif

endmodule

// File: tb/tb_l1_miss_handler.sv
// Self-checking bench for l1_miss_handler: randomized transactions against a
// transaction-level latency/result model derived from the handler's rules.
module tb_l1_miss_handler;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_req_addr;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_data;
  logic          cpu_resp_hit;
  logic          cpu_resp_err;
  logic          l1_read;
  logic          l1_write_enable;
  logic [AW-1:0] l1_addr;
  logic [DW-1:0] l1_write_data;
  logic          l1_hit;
  logic [DW-1:0] l1_read_data;
  logic          l2_req_valid;
  logic          l2_req_ready;
  logic [AW-1:0] l2_req_addr;
  logic          l2_resp_valid;
  logic [DW-1:0] l2_resp_data;
`ifdef L1_MISS_HANDLER_STATS_EN
  logic [15:0]   stat_hits;
  logic [15:0]   stat_misses;
`endif

  int checks = 0;
  int errors = 0;

  // Observed results of the last transaction
  int            obs_lat, obs_fills, obs_l2req, obs_lookups, obs_resps, obs_proto;
  logic [DW-1:0] obs_data, obs_fill_data;
  logic [AW-1:0] obs_fill_addr;
  logic          obs_hit, obs_err, obs_ready_end;

  // Expected results from the model
  int            exp_lat, exp_fills, exp_l2req;
  logic [DW-1:0] exp_data;
  logic          exp_hit, exp_err;

  l1_miss_handler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .L2_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .cpu_resp_hit(cpu_resp_hit), .cpu_resp_err(cpu_resp_err),
    .l1_read(l1_read), .l1_write_enable(l1_write_enable), .l1_addr(l1_addr),
    .l1_write_data(l1_write_data), .l1_hit(l1_hit), .l1_read_data(l1_read_data),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data)
`ifdef L1_MISS_HANDLER_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Cycle 0 is the acceptance cycle. A hit answers in cycle 3. A miss spends
  // a+1 cycles requesting (handshake in cycle 3+a); a response d cycles after
  // the handshake is accepted if d <= T, filling in hs+d+1 and answering in
  // hs+d+2; otherwise the error response comes in cycle hs+T+1.
  task automatic model_txn(input bit hit, input logic [DW-1:0] l1d, input int a,
                           input int d, input logic [DW-1:0] l2d);
    int hs;
    if (hit) begin
      exp_lat = 3; exp_data = l1d; exp_hit = 1'b1; exp_err = 1'b0;
      exp_fills = 0; exp_l2req = 0;
    end else begin
      hs = 3 + a;
      exp_l2req = a + 1;
      exp_hit = 1'b0;
      if (d >= 1 && d <= T) begin
        exp_fills = 1; exp_data = l2d; exp_err = 1'b0; exp_lat = hs + d + 2;
      end else begin
        exp_fills = 0; exp_data = 32'hFFFF_FFFF; exp_err = 1'b1; exp_lat = hs + T + 1;
      end
    end
  endtask

  // Drives one request and plays the L1 and L2 sides; records what the DUT did.
  task automatic run_txn(input logic [AW-1:0] addr, input bit hit, input logic [DW-1:0] l1d,
                         input int a, input int d, input logic [DW-1:0] l2d);
    int c, hs, wait_cnt;
    bit prev_read, done;
    obs_lat = -1; obs_fills = 0; obs_l2req = 0; obs_lookups = 0; obs_resps = 0; obs_proto = 0;
    obs_data = '0; obs_fill_data = '0; obs_fill_addr = '0; obs_hit = 1'b0; obs_err = 1'b0;
    @(negedge clk);
    if (cpu_req_ready !== 1'b1) obs_proto++;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    c = 0; hs = -1; wait_cnt = 0; prev_read = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      c++;
      cpu_req_valid = 1'b0;
      cpu_req_addr  = AW'($urandom);
      if (l1_read === 1'b1) begin
        obs_lookups++;
        if (l1_addr !== addr) obs_proto++;
      end
      if (l1_read === 1'b1 && l1_write_enable === 1'b1) obs_proto++;
      if (l1_write_enable === 1'b1) begin
        obs_fills++; obs_fill_addr = l1_addr; obs_fill_data = l1_write_data;
      end
      if (cpu_resp_valid === 1'b1) begin
        obs_resps++;
        if (obs_lat < 0) begin
          obs_lat = c; obs_data = cpu_resp_data; obs_hit = cpu_resp_hit; obs_err = cpu_resp_err;
        end
      end
      if (obs_lat < 0 && cpu_req_ready !== 1'b0) obs_proto++;
      // L1 answers one cycle after the lookup; junk otherwise
      if (prev_read) begin
        l1_hit = hit; l1_read_data = l1d;
      end else begin
        l1_hit = 1'($urandom_range(0, 1)); l1_read_data = $urandom;
      end
      prev_read = (l1_read === 1'b1);
      if (l2_req_valid === 1'b1) begin
        obs_l2req++;
        if (l2_req_addr !== addr) obs_proto++;
        l2_req_ready = (wait_cnt >= a);
        if (wait_cnt >= a) hs = c;
        wait_cnt++;
      end else begin
        l2_req_ready = 1'($urandom_range(0, 1));
      end
      if (hs >= 0 && c == hs + d) begin
        l2_resp_valid = 1'b1; l2_resp_data = l2d;
      end else if (hs < 0) begin
        l2_resp_valid = ($urandom_range(0, 3) == 0); l2_resp_data = $urandom;
      end else begin
        l2_resp_valid = 1'b0; l2_resp_data = $urandom;
      end
      if (obs_lat >= 0 && c >= obs_lat + 2 && (hs < 0 || d > T + 5 || c > hs + d)) done = 1'b1;
      if (c >= 300) begin
        obs_proto++; done = 1'b1;
      end
    end
    obs_ready_end = cpu_req_ready;
    l1_hit = 1'b0; l2_req_ready = 1'b0; l2_resp_valid = 1'b0;
    $display("txn addr=%h hit=%0d a=%0d d=%0d lat=%0d data=%h rhit=%0d err=%0d fills=%0d",
             addr, hit, a, d, obs_lat, obs_data, obs_hit, obs_err, obs_fills);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cpu_req_ready); end
    checks++; if ({cpu_resp_valid, cpu_resp_hit, cpu_resp_err} !== 3'b000) begin errors++; $display("FAIL reset_resp_flags: got %b expected 000", {cpu_resp_valid, cpu_resp_hit, cpu_resp_err}); end
    checks++; if (cpu_resp_data !== '0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", cpu_resp_data); end
    checks++; if ({l1_read, l1_write_enable} !== 2'b00) begin errors++; $display("FAIL reset_l1_ctrl: got %b expected 00", {l1_read, l1_write_enable}); end
    checks++; if (l1_addr !== '0 || l1_write_data !== '0) begin errors++; $display("FAIL reset_l1_bus: got %h/%h expected 0/0", l1_addr, l1_write_data); end
    checks++; if (l2_req_valid !== 1'b0 || l2_req_addr !== '0) begin errors++; $display("FAIL reset_l2: got %b/%h expected 0/0", l2_req_valid, l2_req_addr); end
  endtask

  task automatic test_hit();
    logic [AW-1:0] addr;
    logic [DW-1:0] d1;
    for (int i = 0; i < 5; i++) begin
      addr = AW'($urandom);
      d1 = (i == 0) ? 32'h1234_5678 : $urandom;
      model_txn(1'b1, d1, 0, 1, '0);
      run_txn(addr, 1'b1, d1, 0, 1, $urandom);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL hit_latency[%0d]: got %0d expected %0d", i, obs_lat, exp_lat); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL hit_data[%0d]: got %h expected %h", i, obs_data, exp_data); end
      checks++; if ({obs_hit, obs_err} !== {exp_hit, exp_err}) begin errors++; $display("FAIL hit_flags[%0d]: got %b expected %b", i, {obs_hit, obs_err}, {exp_hit, exp_err}); end
      checks++; if (obs_l2req !== exp_l2req || obs_fills !== exp_fills) begin errors++; $display("FAIL hit_no_l2[%0d]: got l2req=%0d fills=%0d expected 0/0", i, obs_l2req, obs_fills); end
      checks++; if (obs_resps !== 1 || obs_proto !== 0 || obs_ready_end !== 1'b1) begin errors++; $display("FAIL hit_protocol[%0d]: got resps=%0d proto=%0d ready=%b expected 1/0/1", i, obs_resps, obs_proto, obs_ready_end); end
    end
  endtask

  task automatic test_miss();
    logic [AW-1:0] addr;
    logic [DW-1:0] d2;
    int a, d;
    for (int i = 0; i < 4; i++) begin
      addr = (i == 0) ? 11'h2A0 : AW'($urandom);
      d2   = (i == 0) ? 32'hCAFE_F00D : $urandom;
      a    = (i == 0) ? 2 : int'($urandom_range(0, 3));
      d    = (i == 0) ? 4 : int'($urandom_range(1, T));
      model_txn(1'b0, '0, a, d, d2);
      run_txn(addr, 1'b0, $urandom, a, d, d2);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL miss_latency[%0d]: got %0d expected %0d", i, obs_lat, exp_lat); end
      checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL miss_data[%0d]: got %h expected %h", i, obs_data, exp_data); end
      checks++; if ({obs_hit, obs_err} !== {exp_hit, exp_err}) begin errors++; $display("FAIL miss_flags[%0d]: got %b expected %b", i, {obs_hit, obs_err}, {exp_hit, exp_err}); end
      checks++; if (obs_fills !== exp_fills) begin errors++; $display("FAIL miss_fill_count[%0d]: got %0d expected %0d", i, obs_fills, exp_fills); end
      checks++; if (obs_fill_data !== d2 || obs_fill_addr !== addr) begin errors++; $display("FAIL miss_fill[%0d]: got %h@%h expected %h@%h", i, obs_fill_data, obs_fill_addr, d2, addr); end
      checks++; if (obs_l2req !== exp_l2req) begin errors++; $display("FAIL miss_l2req_cycles[%0d]: got %0d expected %0d", i, obs_l2req, exp_l2req); end
      checks++; if (obs_resps !== 1 || obs_proto !== 0) begin errors++; $display("FAIL miss_protocol[%0d]: got resps=%0d proto=%0d expected 1/0", i, obs_resps, obs_proto); end
    end
  endtask

  task automatic test_timeout();
    int d;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 1000 : T + 1 + i;   // never, or late after the error response
      model_txn(1'b0, '0, i, d, 32'h5555_AAAA);
      run_txn(AW'($urandom), 1'b0, $urandom, i, d, 32'h5555_AAAA);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL timeout_latency[%0d]: got %0d expected %0d", i, obs_lat, exp_lat); end
      checks++; if (obs_data !== 32'hFFFF_FFFF || obs_err !== 1'b1 || obs_hit !== 1'b0) begin errors++; $display("FAIL timeout_resp[%0d]: got %h err=%b hit=%b expected ffffffff err=1 hit=0", i, obs_data, obs_err, obs_hit); end
      checks++; if (obs_fills !== 0 || obs_resps !== 1) begin errors++; $display("FAIL timeout_ignored_late[%0d]: got fills=%0d resps=%0d expected 0/1", i, obs_fills, obs_resps); end
      checks++; if (obs_proto !== 0) begin errors++; $display("FAIL timeout_protocol[%0d]: got %0d expected 0", i, obs_proto); end
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] d2;
    for (int i = 0; i < 2; i++) begin
      d2 = $urandom;
      model_txn(1'b0, '0, i, T, d2);
      run_txn(AW'($urandom), 1'b0, $urandom, i, T, d2);
      checks++; if (obs_err !== 1'b0 || obs_data !== d2) begin errors++; $display("FAIL simul_resp[%0d]: got %h err=%b expected %h err=0", i, obs_data, obs_err, d2); end
      checks++; if (obs_fills !== 1 || obs_fill_data !== d2) begin errors++; $display("FAIL simul_fill[%0d]: got %0d fills data %h expected 1 fill %h", i, obs_fills, obs_fill_data, d2); end
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL simul_latency[%0d]: got %0d expected %0d", i, obs_lat, exp_lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addr;
    logic [DW-1:0] d1, d2;
    bit hit;
    int a, d;
    for (int i = 0; i < 16; i++) begin
      addr = AW'($urandom); d1 = $urandom; d2 = $urandom;
      hit = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, 3));
      d = int'($urandom_range(1, T + 2));
      model_txn(hit, d1, a, d, d2);
      run_txn(addr, hit, d1, a, d, d2);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, obs_lat, exp_lat); end
      checks++; if (obs_data !== exp_data || {obs_hit, obs_err} !== {exp_hit, exp_err}) begin errors++; $display("FAIL b2b_resp[%0d]: got %h %b expected %h %b", i, obs_data, {obs_hit, obs_err}, exp_data, {exp_hit, exp_err}); end
      checks++; if (obs_fills !== exp_fills || obs_l2req !== exp_l2req || obs_lookups !== 1) begin errors++; $display("FAIL b2b_counts[%0d]: got fills=%0d l2req=%0d lookups=%0d expected %0d/%0d/1", i, obs_fills, obs_l2req, obs_lookups, exp_fills, exp_l2req); end
      if (exp_fills == 1) begin
        checks++; if (obs_fill_data !== d2 || obs_fill_addr !== addr) begin errors++; $display("FAIL b2b_fill[%0d]: got %h@%h expected %h@%h", i, obs_fill_data, obs_fill_addr, d2, addr); end
      end
      checks++; if (obs_resps !== 1 || obs_proto !== 0) begin errors++; $display("FAIL b2b_protocol[%0d]: got resps=%0d proto=%0d expected 1/0", i, obs_resps, obs_proto); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int guard, bad;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_addr = 11'h155;
    l1_hit = 1'b0; l2_req_ready = 1'b1; l2_resp_valid = 1'b0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    guard = 0;
    while (l2_req_valid !== 1'b1 && guard < 20) begin
      @(negedge clk); guard++;
    end
    checks++; if (l2_req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_reach_l2: got l2_req_valid=%b expected 1", l2_req_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", cpu_req_ready); end
    checks++; if ({cpu_resp_valid, cpu_resp_err, l1_read, l1_write_enable, l2_req_valid} !== 5'b0 || cpu_resp_data !== '0 || l1_addr !== '0 || l2_req_addr !== '0) begin errors++; $display("FAIL rstmid_outputs: got flags=%b data=%h expected zeros", {cpu_resp_valid, cpu_resp_err, l1_read, l1_write_enable, l2_req_valid}, cpu_resp_data); end
    @(negedge clk);
    rst = 1'b0;
    l2_req_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      l2_resp_valid = 1'b1; l2_resp_data = $urandom;
      @(negedge clk);
      if (cpu_resp_valid !== 1'b0 || l1_write_enable !== 1'b0 || cpu_req_ready !== 1'b1) bad++;
    end
    l2_resp_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_dropped: got %0d bad cycles expected 0", bad); end
    model_txn(1'b0, '0, 1, 3, 32'h0BAD_CAFE);
    run_txn(11'h155, 1'b0, $urandom, 1, 3, 32'h0BAD_CAFE);
    checks++; if (obs_lat !== exp_lat || obs_data !== exp_data || obs_err !== 1'b0 || obs_fills !== 1) begin errors++; $display("FAIL rstmid_next_txn: got lat=%0d data=%h err=%b fills=%0d expected %0d %h 0 1", obs_lat, obs_data, obs_err, obs_fills, exp_lat, exp_data); end
  endtask

`ifdef L1_MISS_HANDLER_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_txn(AW'($urandom), (i < 3), $urandom, 0, 1, $urandom);
    end
    checks++; if (stat_hits !== 16'd3) begin errors++; $display("FAIL stat_hits: got %0d expected 3", stat_hits); end
    checks++; if (stat_misses !== 16'd2) begin errors++; $display("FAIL stat_misses: got %0d expected 2", stat_misses); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_addr = '0;
    l1_hit = 1'b0; l1_read_data = '0;
    l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_data = '0;
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef L1_MISS_HANDLER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
